// File: rtl/ccc_cfg_writer.sv
// ccc_cfg_writer: assembles payload bytes of configuration-changing CCCs
// (SETMWL, SETMRL, SETDASA, SETNEWDA, SETAASA, RSTDAA), validates them and
// emits one registered group of commit strobes per accepted CCC.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   ccc_start_i, ccc_code_i          CCC open pulse and code
//   data_valid_i, data_i, data_last_i payload byte stream (MSB first)
//   ccc_end_i                        STOP/Sr seen
//   dyn_addr_valid_i, sta_addr_i, sta_addr_valid_i  current address state
//   set_mwl_o/mwl_o, set_mrl_o/mrl_o, set_ibil_o/ibil_o  length commits
//   dyn_addr_we_o, dyn_addr_o, dyn_addr_valid_o          address commit
//   proto_err_o                      rejected-CCC pulse
//   busy_o                           not idle
module ccc_cfg_writer #(
  parameter logic [15:0] MinLen = 16'd8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ccc_start_i,
  input  logic [7:0]  ccc_code_i,
  input  logic        data_valid_i,
  input  logic [7:0]  data_i,
  input  logic        data_last_i,
  input  logic        ccc_end_i,
  input  logic        dyn_addr_valid_i,
  input  logic [6:0]  sta_addr_i,
  input  logic        sta_addr_valid_i,
  output logic        set_mwl_o,
  output logic [15:0] mwl_o,
  output logic        set_mrl_o,
  output logic [15:0] mrl_o,
  output logic        set_ibil_o,
  output logic [7:0]  ibil_o,
  output logic        dyn_addr_we_o,
  output logic [6:0]  dyn_addr_o,
  output logic        dyn_addr_valid_o,
  output logic        proto_err_o,
  output logic        busy_o
);

  localparam int unsigned ByteW = 8;
  localparam int unsigned LenW  = 16;
  localparam int unsigned AddrW = 7;

  localparam logic [ByteW-1:0] CodeSetMwlBc = 8'h09;
  localparam logic [ByteW-1:0] CodeSetMwlDc = 8'h89;
  localparam logic [ByteW-1:0] CodeSetMrlBc = 8'h0A;
  localparam logic [ByteW-1:0] CodeSetMrlDc = 8'h8A;
  localparam logic [ByteW-1:0] CodeSetDasa  = 8'h87;
  localparam logic [ByteW-1:0] CodeSetNewDa = 8'h88;
  localparam logic [ByteW-1:0] CodeSetAasa  = 8'h29;
  localparam logic [ByteW-1:0] CodeRstDaa   = 8'h06;

  localparam logic [AddrW-1:0] AddrBcast = 7'h7E;

  typedef enum logic [2:0] {
    StIdle,
    StB0,
    StB1,
    StB2,
    StCommit,
    StDrain
  } state_e;

  // Largest payload byte count a code may carry.
  function automatic logic [1:0] max_bytes(input logic [ByteW-1:0] code);
    case (code)
      CodeSetMwlBc, CodeSetMwlDc: max_bytes = 2'd2;
      CodeSetMrlBc, CodeSetMrlDc: max_bytes = 2'd3;
      CodeSetDasa, CodeSetNewDa:  max_bytes = 2'd1;
      default:                    max_bytes = 2'd0;
    endcase
  endfunction

  // Byte counts that may legally end a payload CCC.
  function automatic logic count_ok(input logic [ByteW-1:0] code, input logic [2:0] n);
    case (code)
      CodeSetMwlBc, CodeSetMwlDc: count_ok = (n == 3'd2);
      CodeSetMrlBc, CodeSetMrlDc: count_ok = (n == 3'd2) || (n == 3'd3);
      CodeSetDasa, CodeSetNewDa:  count_ok = (n == 3'd1);
      default:                    count_ok = 1'b0;
    endcase
  endfunction

  function automatic logic is_handled(input logic [ByteW-1:0] code);
    case (code)
      CodeSetMwlBc, CodeSetMwlDc, CodeSetMrlBc, CodeSetMrlDc,
      CodeSetDasa, CodeSetNewDa, CodeSetAasa, CodeRstDaa: is_handled = 1'b1;
      default: is_handled = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [ByteW-1:0] code_q, code_d;
  logic [ByteW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_arm_q, err_arm_d;
  logic             drain_exit_q, drain_exit_d;

  logic             set_mwl_q, set_mwl_d;
  logic [LenW-1:0]  mwl_q, mwl_d;
  logic             set_mrl_q, set_mrl_d;
  logic [LenW-1:0]  mrl_q, mrl_d;
  logic             set_ibil_q, set_ibil_d;
  logic [ByteW-1:0] ibil_q, ibil_d;
  logic             dyn_we_q, dyn_we_d;
  logic [AddrW-1:0] dyn_addr_q, dyn_addr_d;
  logic             dyn_val_q, dyn_val_d;
  logic             proto_err_q, proto_err_d;
  logic             busy_q, busy_d;

  logic [2:0]       new_cnt;
  logic             last_c;
  logic             go_drain;
  logic [LenW-1:0]  len_val;
  logic [AddrW-1:0] da_val;

  // Next-state, payload capture and commit validation.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    cnt_d        = cnt_q;
    err_arm_d    = 1'b0;
    drain_exit_d = drain_exit_q;
    set_mwl_d    = 1'b0;
    mwl_d        = mwl_q;
    set_mrl_d    = 1'b0;
    mrl_d        = mrl_q;
    set_ibil_d   = 1'b0;
    ibil_d       = ibil_q;
    dyn_we_d     = 1'b0;
    dyn_addr_d   = dyn_addr_q;
    dyn_val_d    = dyn_val_q;
    // Drain entry arms a one-shot error that lands one cycle later, in step with commit.
    proto_err_d  = err_arm_q;
    go_drain     = 1'b0;
    new_cnt      = {1'b0, cnt_q} + 3'd1;
    // A byte that coincides with STOP/Sr is treated as the final byte.
    last_c       = data_last_i | ccc_end_i;
    len_val      = {b0_q, b1_q};
    da_val       = b0_q[7:1];

    case (state_q)
      StIdle: ;
      StB0, StB1, StB2: begin
        if (data_valid_i) begin
          if (state_q == StB0) begin
            b0_d = data_i;
          end else if (state_q == StB1) begin
            b1_d = data_i;
          end else begin
            b2_d = data_i;
          end
          cnt_d = new_cnt[1:0];
          if (new_cnt > {1'b0, max_bytes(code_q)}) begin
            go_drain = 1'b1;
          end else if (last_c) begin
            if (count_ok(code_q, new_cnt)) begin
              state_d = StCommit;
            end else begin
              go_drain = 1'b1;
            end
          end else if (new_cnt == 3'd3) begin
            // No capture slot remains; any further byte would overflow.
            go_drain = 1'b1;
          end else begin
            state_d = (state_q == StB0) ? StB1 : StB2;
          end
        end else if (ccc_end_i) begin
          state_d = (max_bytes(code_q) == 2'd0) ? StCommit : StIdle;
        end
      end
      StCommit: begin
        state_d = StIdle;
        case (code_q)
          CodeSetMwlBc, CodeSetMwlDc: begin
            if (len_val < MinLen) begin
              proto_err_d = 1'b1;
            end else begin
              set_mwl_d = 1'b1;
              mwl_d     = len_val;
            end
          end
          CodeSetMrlBc, CodeSetMrlDc: begin
            if (len_val < MinLen) begin
              proto_err_d = 1'b1;
            end else begin
              set_mrl_d = 1'b1;
              mrl_d     = len_val;
              if (cnt_q == 2'd3) begin
                set_ibil_d = 1'b1;
                ibil_d     = b2_q;
              end
            end
          end
          CodeSetDasa, CodeSetNewDa: begin
            // Precondition failure is silent; content failure is an error.
            if (dyn_addr_valid_i == (code_q == CodeSetNewDa)) begin
              if (b0_q[0] || (da_val == 7'h00) || (da_val == AddrBcast)) begin
                proto_err_d = 1'b1;
              end else begin
                dyn_we_d   = 1'b1;
                dyn_addr_d = da_val;
                dyn_val_d  = 1'b1;
              end
            end
          end
          CodeSetAasa: begin
            if (sta_addr_valid_i && !dyn_addr_valid_i) begin
              dyn_we_d   = 1'b1;
              dyn_addr_d = sta_addr_i;
              dyn_val_d  = 1'b1;
            end
          end
          CodeRstDaa: begin
            dyn_we_d   = 1'b1;
            dyn_addr_d = '0;
            dyn_val_d  = 1'b0;
          end
          default: ;
        endcase
      end
      StDrain: begin
        if (drain_exit_q || (data_valid_i && last_c) || ccc_end_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_drain) begin
      state_d      = StDrain;
      err_arm_d    = 1'b1;
      drain_exit_d = last_c;
    end

    // A new CCC always wins and silently discards any partial one.
    if (ccc_start_i) begin
      err_arm_d    = 1'b0;
      drain_exit_d = 1'b0;
      if (is_handled(ccc_code_i)) begin
        state_d = StB0;
        code_d  = ccc_code_i;
        cnt_d   = 2'd0;
      end else begin
        state_d = StIdle;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      code_q       <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      cnt_q        <= '0;
      err_arm_q    <= 1'b0;
      drain_exit_q <= 1'b0;
      set_mwl_q    <= 1'b0;
      mwl_q        <= '0;
      set_mrl_q    <= 1'b0;
      mrl_q        <= '0;
      set_ibil_q   <= 1'b0;
      ibil_q       <= '0;
      dyn_we_q     <= 1'b0;
      dyn_addr_q   <= '0;
      dyn_val_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      cnt_q        <= cnt_d;
      err_arm_q    <= err_arm_d;
      drain_exit_q <= drain_exit_d;
      set_mwl_q    <= set_mwl_d;
      mwl_q        <= mwl_d;
      set_mrl_q    <= set_mrl_d;
      mrl_q        <= mrl_d;
      set_ibil_q   <= set_ibil_d;
      ibil_q       <= ibil_d;
      dyn_we_q     <= dyn_we_d;
      dyn_addr_q   <= dyn_addr_d;
      dyn_val_q    <= dyn_val_d;
      proto_err_q  <= proto_err_d;
      busy_q       <= busy_d;
    end
  end

  assign set_mwl_o        = set_mwl_q;
  assign mwl_o            = mwl_q;
  assign set_mrl_o        = set_mrl_q;
  assign mrl_o            = mrl_q;
  assign set_ibil_o       = set_ibil_q;
  assign ibil_o           = ibil_q;
  assign dyn_addr_we_o    = dyn_we_q;
  assign dyn_addr_o       = dyn_addr_q;
  assign dyn_addr_valid_o = dyn_val_q;
  assign proto_err_o      = proto_err_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_ccc_cfg_writer.sv
// tb_ccc_cfg_writer: directed CCC sequences against a transaction-level model
// of ccc_cfg_writer; outputs compared every cycle on the falling edge.
module tb_ccc_cfg_writer;

  localparam logic [15:0] MIN_LEN = 16'd8;

  logic        clk_i;
  logic        rst_ni;
  logic        ccc_start_i;
  logic [7:0]  ccc_code_i;
  logic        data_valid_i;
  logic [7:0]  data_i;
  logic        data_last_i;
  logic        ccc_end_i;
  logic        dyn_addr_valid_i;
  logic [6:0]  sta_addr_i;
  logic        sta_addr_valid_i;
  logic        set_mwl_o;
  logic [15:0] mwl_o;
  logic        set_mrl_o;
  logic [15:0] mrl_o;
  logic        set_ibil_o;
  logic [7:0]  ibil_o;
  logic        dyn_addr_we_o;
  logic [6:0]  dyn_addr_o;
  logic        dyn_addr_valid_o;
  logic        proto_err_o;
  logic        busy_o;

  ccc_cfg_writer #(.MinLen(MIN_LEN)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ccc_start_i      (ccc_start_i),
    .ccc_code_i       (ccc_code_i),
    .data_valid_i     (data_valid_i),
    .data_i           (data_i),
    .data_last_i      (data_last_i),
    .ccc_end_i        (ccc_end_i),
    .dyn_addr_valid_i (dyn_addr_valid_i),
    .sta_addr_i       (sta_addr_i),
    .sta_addr_valid_i (sta_addr_valid_i),
    .set_mwl_o        (set_mwl_o),
    .mwl_o            (mwl_o),
    .set_mrl_o        (set_mrl_o),
    .mrl_o            (mrl_o),
    .set_ibil_o       (set_ibil_o),
    .ibil_o           (ibil_o),
    .dyn_addr_we_o    (dyn_addr_we_o),
    .dyn_addr_o       (dyn_addr_o),
    .dyn_addr_valid_o (dyn_addr_valid_o),
    .proto_err_o      (proto_err_o),
    .busy_o           (busy_o)
  );

  typedef struct packed {
    logic [31:0] at;
    logic        mwl_s;
    logic        mrl_s;
    logic        ibil_s;
    logic        we;
    logic        err;
    logic [15:0] mwl;
    logic [15:0] mrl;
    logic [7:0]  ibil;
    logic [6:0]  da;
    logic        dav;
  } ev_t;

  ev_t         eq[$];
  logic [31:0] cyc;
  int          checks;
  int          errors;
  int          n_mwl;
  int          n_err;
  logic [15:0] m_mwl;
  logic [15:0] m_mrl;
  logic [7:0]  m_ibil;
  logic [6:0]  m_da;
  logic        m_dav;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one complete CCC, from the command rules alone.
  // mode 0: last flag on final byte, 1: STOP after bytes, 2: STOP with final byte.
  function automatic ev_t predict(input logic [7:0] code, input int n,
                                  input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input int mode);
    ev_t         e;
    logic [15:0] v;
    logic [6:0]  a;
    bit          payload_code;
    e = '0;
    v = {b0, b1};
    a = b0[7:1];
    payload_code = (code inside {8'h09, 8'h89, 8'h0A, 8'h8A, 8'h87, 8'h88});
    if (payload_code && mode == 1) return e;
    case (code)
      8'h09, 8'h89: begin
        if (n != 2 || v < MIN_LEN) e.err = 1'b1;
        else begin e.mwl_s = 1'b1; e.mwl = v; end
      end
      8'h0A, 8'h8A: begin
        if (n < 2 || n > 3 || v < MIN_LEN) e.err = 1'b1;
        else begin
          e.mrl_s = 1'b1; e.mrl = v;
          if (n == 3) begin e.ibil_s = 1'b1; e.ibil = b2; end
        end
      end
      8'h87, 8'h88: begin
        if (n != 1) e.err = 1'b1;
        else if (dyn_addr_valid_i == (code == 8'h88)) begin
          if (b0[0] || a == 7'h00 || a == 7'h7E) e.err = 1'b1;
          else begin e.we = 1'b1; e.da = a; e.dav = 1'b1; end
        end
      end
      8'h29: begin
        if (n > 0) e.err = 1'b1;
        else if (sta_addr_valid_i && !dyn_addr_valid_i) begin
          e.we = 1'b1; e.da = sta_addr_i; e.dav = 1'b1;
        end
      end
      8'h06: begin
        if (n > 0) e.err = 1'b1;
        else begin e.we = 1'b1; e.da = 7'h00; e.dav = 1'b0; end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    ccc_start_i  = 1'b0;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    ccc_end_i    = 1'b0;
    data_i       = 8'h00;
  endtask

  task automatic run_ccc(input logic [7:0] code, input int n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input int mode);
    logic [7:0] bb [3];
    ev_t        e;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    tick(); idle_in();
    ccc_start_i = 1'b1;
    ccc_code_i  = code;
    for (int i = 0; i < n; i++) begin
      tick(); idle_in();
      data_valid_i = 1'b1;
      data_i       = bb[i];
      if (i == n - 1 && mode == 0) data_last_i = 1'b1;
      if (i == n - 1 && mode == 2) ccc_end_i = 1'b1;
    end
    if (mode == 1) begin
      tick(); idle_in();
      ccc_end_i = 1'b1;
    end
    e = predict(code, n, b0, b1, b2, mode);
    if (e.mwl_s | e.mrl_s | e.ibil_s | e.we | e.err) begin
      e.at = cyc + 32'd2;
      eq.push_back(e);
    end
    tick(); idle_in();
    repeat (3) tick();
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_mwl = '0; m_mrl = '0; m_ibil = '0; m_da = '0; m_dav = 1'b0;
        chk("rst_strobes", 32'({set_mwl_o, set_mrl_o, set_ibil_o, dyn_addr_we_o, proto_err_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
      end else begin
        logic [4:0] es;
        es = 5'b0;
        if (eq.size() != 0 && eq[0].at == cyc) begin
          ev_t e;
          e = eq.pop_front();
          es = {e.mwl_s, e.mrl_s, e.ibil_s, e.we, e.err};
          if (e.mwl_s) m_mwl = e.mwl;
          if (e.mrl_s) m_mrl = e.mrl;
          if (e.ibil_s) m_ibil = e.ibil;
          if (e.we) begin m_da = e.da; m_dav = e.dav; end
        end
        if (set_mwl_o) n_mwl++;
        if (proto_err_o) n_err++;
        chk("strobes", 32'({set_mwl_o, set_mrl_o, set_ibil_o, dyn_addr_we_o, proto_err_o}), 32'(es));
        chk("mwl", 32'(mwl_o), 32'(m_mwl));
        chk("mrl", 32'(mrl_o), 32'(m_mrl));
        chk("ibil", 32'(ibil_o), 32'(m_ibil));
        chk("dyn_addr", 32'({dyn_addr_valid_o, dyn_addr_o}), 32'({m_dav, m_da}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = '0; checks = 0; errors = 0; n_mwl = 0; n_err = 0;
    rst_ni = 1'b0;
    ccc_code_i = 8'h00;
    dyn_addr_valid_i = 1'b0; sta_addr_i = 7'h00; sta_addr_valid_i = 1'b0;
    idle_in();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk("lit_reset_mwl", 32'(mwl_o), 32'h0);
    repeat (2) tick();

    run_ccc(8'h89, 2, 8'h01, 8'h00, 8'h00, 0);
    chk("lit_mwl_0100", 32'(mwl_o), 32'h0100);
    chk("lit_mwl_once", 32'(n_mwl), 32'd1);
    run_ccc(8'h0A, 3, 8'h00, 8'h40, 8'h10, 0);
    chk("lit_mrl_0040", 32'(mrl_o), 32'h0040);
    chk("lit_ibil_10", 32'(ibil_o), 32'h10);
    run_ccc(8'h09, 1, 8'h01, 8'h00, 8'h00, 0);
    chk("lit_err_short", 32'(n_err), 32'd1);
    chk("lit_mwl_kept", 32'(mwl_o), 32'h0100);
    run_ccc(8'h8A, 2, 8'h00, 8'h04, 8'h00, 0);
    chk("lit_mrl_kept", 32'(mrl_o), 32'h0040);
    run_ccc(8'h8A, 2, 8'h02, 8'h00, 8'h00, 0);
    run_ccc(8'h09, 2, 8'h00, 8'h08, 8'h00, 0);
    chk("lit_mwl_min", 32'(mwl_o), 32'h0008);
    run_ccc(8'h09, 2, 8'h00, 8'h07, 8'h00, 0);

    dyn_addr_valid_i = 1'b0;
    run_ccc(8'h87, 1, 8'h52, 8'h00, 8'h00, 0);
    chk("lit_dasa_addr", 32'({dyn_addr_valid_o, dyn_addr_o}), 32'h0A9);
    run_ccc(8'h87, 1, 8'hFC, 8'h00, 8'h00, 0);
    run_ccc(8'h87, 1, 8'h53, 8'h00, 8'h00, 0);
    run_ccc(8'h87, 1, 8'h00, 8'h00, 8'h00, 0);
    run_ccc(8'h87, 2, 8'h52, 8'h52, 8'h00, 0);
    dyn_addr_valid_i = 1'b1;
    run_ccc(8'h87, 1, 8'h52, 8'h00, 8'h00, 0);
    run_ccc(8'h88, 1, 8'hA4, 8'h00, 8'h00, 0);
    dyn_addr_valid_i = 1'b0;
    run_ccc(8'h88, 1, 8'hA6, 8'h00, 8'h00, 0);

    run_ccc(8'h06, 0, 8'h00, 8'h00, 8'h00, 1);
    chk("lit_rstdaa", 32'({dyn_addr_valid_o, dyn_addr_o}), 32'h000);
    sta_addr_i = 7'h3A; sta_addr_valid_i = 1'b1;
    run_ccc(8'h29, 0, 8'h00, 8'h00, 8'h00, 1);
    chk("lit_aasa", 32'({dyn_addr_valid_o, dyn_addr_o}), 32'h0BA);
    sta_addr_i = 7'h11;
    dyn_addr_valid_i = 1'b1;
    run_ccc(8'h29, 0, 8'h00, 8'h00, 8'h00, 1);
    dyn_addr_valid_i = 1'b0; sta_addr_valid_i = 1'b0;
    run_ccc(8'h29, 0, 8'h00, 8'h00, 8'h00, 1);

    run_ccc(8'h09, 1, 8'h01, 8'h00, 8'h00, 1);
    run_ccc(8'h55, 2, 8'h11, 8'h22, 8'h00, 0);
    run_ccc(8'h89, 2, 8'h00, 8'h20, 8'h00, 2);
    chk("lit_mwl_end", 32'(mwl_o), 32'h0020);
    run_ccc(8'h06, 1, 8'h00, 8'h00, 8'h00, 0);

    // Partial SETMWL abandoned by a fresh SETMRL.
    tick(); idle_in(); ccc_start_i = 1'b1; ccc_code_i = 8'h09;
    tick(); idle_in(); data_valid_i = 1'b1; data_i = 8'h05;
    run_ccc(8'h0A, 2, 8'h00, 8'h30, 8'h00, 0);
    chk("lit_restart_mwl", 32'(mwl_o), 32'h0020);
    run_ccc(8'h0A, 3, 8'h00, 8'h04, 8'h10, 0);
    chk("lit_err_total", 32'(n_err), 32'd9);

    // Reset in the middle of a SETMWL.
    tick(); idle_in(); ccc_start_i = 1'b1; ccc_code_i = 8'h89;
    tick(); idle_in(); data_valid_i = 1'b1; data_i = 8'h01;
    tick(); idle_in();
    chk("lit_busy_mid", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #2;
    chk("lit_rst_mid_vals", 32'({mwl_o, mrl_o}), 32'h0);
    chk("lit_rst_mid_addr", 32'({ibil_o, dyn_addr_valid_o, dyn_addr_o}), 32'h0);
    chk("lit_rst_mid_busy", 32'(busy_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    repeat (6) tick();

    chk("queue_drained", 32'(eq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccc_cfg_writer.md
# ccc_cfg_writer

Assembles payload bytes of configuration-changing CCCs into committed configuration updates: max write length, max read length, max IBI length, and dynamic address assignment or reset. The CCC decoder drives it with a byte stream. Its strobes feed the `set_mwl_i`, `set_mrl_i` and `set_ibil_i` inputs of the configuration block and the dynamic-address CSR update path. It covers the write direction of the configuration interface, where the bus changes target configuration, and validates payload length and content before any update is committed.

## Interface
Parameters:
- `MinLen`, default 16'd8: smallest MWL/MRL value accepted; smaller values are rejected.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ccc_start_i` in 1: one-cycle pulse that opens a CCC.
- `ccc_code_i` in 8: CCC code, sampled when `ccc_start_i` is high.
- `data_valid_i` in 1: payload byte valid.
- `data_i` in 8: payload byte, MSB-first order.
- `data_last_i` in 1: marks the final byte; only meaningful with `data_valid_i`.
- `ccc_end_i` in 1: STOP or Sr seen. Ends a CCC that has no payload, or abandons a partial payload.
- `dyn_addr_valid_i` in 1: current dynamic address valid bit.
- `sta_addr_i` in 7: current static address.
- `sta_addr_valid_i` in 1: current static address valid bit.
- `set_mwl_o` out 1, `mwl_o` out 16: MWL commit strobe and value.
- `set_mrl_o` out 1, `mrl_o` out 16: MRL commit strobe and value.
- `set_ibil_o` out 1, `ibil_o` out 8: IBI length commit strobe and value.
- `dyn_addr_we_o` out 1: dynamic address write strobe.
- `dyn_addr_o` out 7: dynamic address to write.
- `dyn_addr_valid_o` out 1: valid bit to write with `dyn_addr_o`.
- `proto_err_o` out 1: one-cycle pulse when a CCC is rejected.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
Handled codes (any other code leaves the block in IDLE with no action):
- 0x09/0x89 SETMWL: exactly 2 bytes.
- 0x0A/0x8A SETMRL: 2 or 3 bytes; the optional 3rd byte is IBIL.
- 0x87 SETDASA: 1 byte; accepted only if `dyn_addr_valid_i`=0.
- 0x88 SETNEWDA: 1 byte; accepted only if `dyn_addr_valid_i`=1.
- 0x29 SETAASA: no payload; accepted only if `sta_addr_valid_i`=1 and `dyn_addr_valid_i`=0.
- 0x06 RSTDAA: no payload.

State machine: IDLE, B0, B1, B2, COMMIT, DRAIN.
- IDLE → B0 on `ccc_start_i` with a handled code. The code is latched into `code_q`.
- B0/B1/B2 each capture a byte into the corresponding payload register on `data_valid_i`, then advance to the next B state.
- B state → COMMIT when `data_last_i` arrives and the byte count is legal for `code_q`.
- B state → DRAIN when `data_last_i` arrives with an illegal count, or a byte arrives beyond the legal maximum.
- B0 → COMMIT on `ccc_end_i` for the no-payload codes (SETAASA, RSTDAA).
- `ccc_end_i` in any B state for a payload code → IDLE. No commit and no error (transfer was abandoned).
- COMMIT → IDLE after one cycle; it performs the validation and emits exactly one group of strobes.
- DRAIN → IDLE on `data_last_i`, `ccc_end_i`, or when entered at `data_last_i`. `proto_err_o` pulses once, on entry to DRAIN.

Commit rules:
- MWL and MRL are {B0,B1}. A value below `MinLen` is rejected: no strobe, `proto_err_o` pulses.
- A 3-byte SETMRL also strobes `set_ibil_o` with `ibil_o`=B2, in the same cycle as `set_mrl_o`.
- SETDASA/SETNEWDA: address is B0[7:1]. Rejected if B0[0]=1, the address is 7'h00, or the address is 7'h7E. On acceptance, `dyn_addr_we_o`=1 and `dyn_addr_valid_o`=1.
- SETAASA writes `dyn_addr_o`=`sta_addr_i` with valid 1.
- RSTDAA writes `dyn_addr_o`=0 with valid 0.
- A failed precondition (valid-bit checks) is rejected silently: no strobe and no error.

## Timing
- All outputs are registered.
- Reset values: all strobes 0, `mwl_o`=`mrl_o`=16'd0, `ibil_o`=0, `dyn_addr_o`=0, `dyn_addr_valid_o`=0, `busy_o`=0, state IDLE.
- Value outputs hold their last committed value between strobes.
- Strobes and `proto_err_o` are single-cycle and assert 2 cycles after the `data_last_i` beat. For no-payload codes they assert 2 cycles after `ccc_end_i`.
- `ccc_start_i` outside IDLE restarts capture with the new code; the partial CCC is discarded without error.
- When `data_valid_i` and `ccc_end_i` are high together, the byte is processed first and `data_last_i` is implied.
- Reset mid-CCC returns to IDLE immediately, with no strobe issued.

## Test plan
- SETMWL 0x89, bytes 0x01,0x00 (last) → `set_mwl_o` pulses once, `mwl_o`=16'h0100, 2 cycles after last.
- SETMRL 0x0A, bytes 0x00,0x40,0x10 (last) → `set_mrl_o`/`set_ibil_o` pulse in the same cycle; `mrl_o`=0x0040, `ibil_o`=0x10.
- SETMWL with a single byte (last) → `proto_err_o` pulses, no strobe, `mwl_o` unchanged. SETMRL value 0x0004 → error, no strobe.
- SETDASA byte 0x52 with `dyn_addr_valid_i`=0 → `dyn_addr_we_o`, `dyn_addr_o`=7'h29, valid 1. Byte 0xFC (address 0x7E) → error. Same CCC with `dyn_addr_valid_i`=1 → nothing.
- RSTDAA then `ccc_end_i` → `dyn_addr_we_o` with valid 0. SETAASA with `sta_addr_i`=7'h3A and both valid bits set correctly → address 0x3A, valid 1.
- SETMWL, one byte, then `ccc_end_i` → IDLE, no error. Assert reset after the first byte → all outputs at reset values, no strobe.
